hps_pio_bank: RTL and testbench

- Parametrised Avalon-MM PIO bank; successor to the single-channel, 16-bit, output-only PIO slaves on the HPS lightweight bridge.
- Provides CHANNELS independent channels of DATA_WIDTH bits. Each channel has:
  - an output register with atomic bit-set and bit-clear aliases;
  - a synchronised input port with rising-edge capture;
  - a per-bit interrupt mask.
- Drives neural-network control and address lines, and collects done/status strobes back to the HPS.

---
 rtl/hps_pio_pkg.sv | 15 +
 rtl/hps_pio_channel.sv | 80 ++++++++
 rtl/hps_pio_bank.sv | 96 +++++++++
 tb/tb_hps_pio_bank.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_pio_pkg.sv
// Register map and shared types for the hps_pio_bank Avalon-MM PIO slave.
package hps_pio_pkg;

   localparam int REG_FIELD_W = 3;

   typedef logic [REG_FIELD_W-1:0] reg_sel_t;

   localparam reg_sel_t REG_DATA  = 3'd0;
   localparam reg_sel_t REG_IN    = 3'd1;
   localparam reg_sel_t REG_MASK  = 3'd2;
   localparam reg_sel_t REG_EDGE  = 3'd3;
   localparam reg_sel_t REG_SET   = 3'd4;
   localparam reg_sel_t REG_CLEAR = 3'd5;

endpackage

// File: rtl/hps_pio_channel.sv
// One PIO channel: out register with set/clear aliases, input synchroniser,
// sticky rising-edge capture and interrupt mask.
module hps_pio_channel
   import hps_pio_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  reg_sel_t              reg_sel,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] in_bits,
   output logic [DATA_WIDTH-1:0] out_bits,
   output logic [DATA_WIDTH-1:0] rd_val,
   output logic                  irq_any
);

   localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] out_r, mask_r, edge_r;
   logic [DATA_WIDTH-1:0] sync1_r, sync2_r, hist_r;
   logic [DATA_WIDTH-1:0] out_nxt_s, mask_nxt_s, clr_s, rise_s;

   // Decode a write into next out/mask values and the edge clear mask.
   always_comb begin
      out_nxt_s  = out_r;
      mask_nxt_s = mask_r;
      clr_s      = ZERO;
      if (wr_en) begin
         case (reg_sel)
            REG_DATA:  out_nxt_s  = wdata;
            REG_MASK:  mask_nxt_s = wdata;
            REG_EDGE:  clr_s      = wdata;
            REG_SET:   out_nxt_s  = out_r | wdata;
            REG_CLEAR: out_nxt_s  = out_r & ~wdata;
            default:   out_nxt_s  = out_r;
         endcase
      end else begin
         out_nxt_s = out_r;
      end
   end

   assign rise_s = sync2_r & ~hist_r;

   // Register state; a new edge overrides a same-cycle write-1-to-clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_r   <= RESET_VALUE;
         mask_r  <= ZERO;
         edge_r  <= ZERO;
         sync1_r <= ZERO;
         sync2_r <= ZERO;
         hist_r  <= ZERO;
      end else begin
         out_r   <= out_nxt_s;
         mask_r  <= mask_nxt_s;
         edge_r  <= (edge_r & ~clr_s) | rise_s;
         sync1_r <= in_bits;
         sync2_r <= sync1_r;
         hist_r  <= sync2_r;
      end
   end

   // Read mux over the pre-write register state.
   always_comb begin
      case (reg_sel)
         REG_DATA: rd_val = out_r;
         REG_IN:   rd_val = sync2_r;
         REG_MASK: rd_val = mask_r;
         REG_EDGE: rd_val = edge_r;
         default:  rd_val = ZERO;
      endcase
   end

   assign out_bits = out_r;
   assign irq_any  = |(edge_r & mask_r);

endmodule

// File: rtl/hps_pio_bank.sv
// Avalon-MM PIO bank: address decode, registered read port and irq reduction
// over CHANNELS instances of hps_pio_channel.
module hps_pio_bank
   import hps_pio_pkg::*;
#(
   parameter int                    CHANNELS    = 4,
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
   parameter int                    ADDR_WIDTH  = $clog2(CHANNELS) + 3
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [ADDR_WIDTH-1:0]          address,
   input  logic                           chipselect,
   input  logic                           read,
   input  logic                           write_n,
   input  logic [31:0]                    writedata,
   output logic [31:0]                    readdata,
   output logic                           readdatavalid,
   input  logic [CHANNELS*DATA_WIDTH-1:0] in_port,
   output logic [CHANNELS*DATA_WIDTH-1:0] out_port,
   output logic                           irq
);

   localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

   logic                  wr_acc_s, rd_acc_s;
   logic [7:0]            ch_s;
   reg_sel_t              reg_s;
   logic [DATA_WIDTH-1:0] rd_val_s [CHANNELS];
   logic [DATA_WIDTH-1:0] rd_sel_s;
   logic [CHANNELS-1:0]   irq_vec_s;
   logic [31:0]           readdata_r;
   logic                  readdatavalid_r, irq_r;

   assign wr_acc_s = chipselect & ~write_n;
   assign rd_acc_s = chipselect & read;
   // Shift rather than slice so a single-channel bank (no channel field) still elaborates.
   assign ch_s     = 8'(address >> 3'd3);
   assign reg_s    = address[REG_FIELD_W-1:0];

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         hps_pio_channel #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_en    (wr_acc_s && (ch_s == 8'(c))),
            .reg_sel  (reg_s),
            .wdata    (writedata[DATA_WIDTH-1:0]),
            .in_bits  (in_port[c*DATA_WIDTH +: DATA_WIDTH]),
            .out_bits (out_port[c*DATA_WIDTH +: DATA_WIDTH]),
            .rd_val   (rd_val_s[c]),
            .irq_any  (irq_vec_s[c])
         );
      end
      if (DATA_WIDTH < 32) begin : g_wd_unused
         logic unused_wd_s;
         assign unused_wd_s = ^writedata[31:DATA_WIDTH];
      end
   endgenerate

   // Channel select for reads; unpopulated channel codes read as zero.
   always_comb begin
      rd_sel_s = ZERO;
      for (int c = 0; c < CHANNELS; c++) begin
         if (ch_s == 8'(c)) begin
            rd_sel_s = rd_val_s[c];
         end else begin
            rd_sel_s = rd_sel_s;
         end
      end
   end

   // Read port and interrupt output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_r      <= 32'h0000_0000;
         readdatavalid_r <= 1'b0;
         irq_r           <= 1'b0;
      end else begin
         if (rd_acc_s) begin
            readdata_r <= 32'(rd_sel_s);
         end
         readdatavalid_r <= rd_acc_s;
         irq_r           <= |irq_vec_s;
      end
   end

   assign readdata      = readdata_r;
   assign readdatavalid = readdatavalid_r;
   assign irq           = irq_r;

endmodule

// File: tb/tb_hps_pio_bank.sv
// Self-checking bench for hps_pio_bank: directed scenarios plus random bus and
// input traffic, checked every cycle against a behavioural model.
module tb_hps_pio_bank;

   // Five channels so the 3-bit channel field has unpopulated codes (5..7).
   localparam int CH = 5;
   localparam int DW = 16;
   localparam int AW = $clog2(CH) + 3;
   localparam int NB = CH * DW;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] address;
   logic          chipselect, read, write_n;
   logic [31:0]   writedata, readdata;
   logic          readdatavalid, irq;
   logic [NB-1:0] in_port, out_port;

   hps_pio_bank #(
      .CHANNELS    (CH),
      .DATA_WIDTH  (DW),
      .RESET_VALUE (16'h0000)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .chipselect    (chipselect),
      .read          (read),
      .write_n       (write_n),
      .writedata     (writedata),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .in_port       (in_port),
      .out_port      (out_port),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Model state: software-visible registers plus the last three input samples.
   logic [DW-1:0] out_m [CH];
   logic [DW-1:0] mask_m[CH];
   logic [DW-1:0] edge_m[CH];
   logic [DW-1:0] smp1[CH], smp2[CH], smp3[CH];
   logic [31:0]   exp_rd;
   logic          exp_rdv, exp_irq;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         out_m[c] = 16'h0000; mask_m[c] = 16'h0000; edge_m[c] = 16'h0000;
         smp1[c] = 16'h0000; smp2[c] = 16'h0000; smp3[c] = 16'h0000;
      end
      exp_rd = 32'h0; exp_rdv = 1'b0; exp_irq = 1'b0;
   endtask

   function automatic logic [31:0] model_read(int ch, int rg);
      if (ch >= CH) return 32'h0;
      case (rg)
         0:       return 32'(out_m[ch]);
         1:       return 32'(smp2[ch]);   // input as seen two edges ago
         2:       return 32'(mask_m[ch]);
         3:       return 32'(edge_m[ch]);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [NB-1:0] model_out();
      logic [NB-1:0] v;
      for (int c = 0; c < CH; c++) v[c*DW +: DW] = out_m[c];
      return v;
   endfunction

   // Advance the model by one clock edge using the bus/input values present at it.
   task automatic model_step();
      int            ch, rg;
      logic [DW-1:0] wd, rise, clr;
      logic          any;
      if (!reset_n) begin
         model_reset();
         return;
      end
      ch = int'(address >> 3);
      rg = int'(address[2:0]);
      wd = writedata[DW-1:0];
      exp_rdv = chipselect && read;
      if (exp_rdv) exp_rd = model_read(ch, rg);
      any = 1'b0;
      for (int c = 0; c < CH; c++) if ((edge_m[c] & mask_m[c]) != 16'h0) any = 1'b1;
      exp_irq = any;
      for (int c = 0; c < CH; c++) begin
         rise = smp2[c] & ~smp3[c];
         clr  = 16'h0000;
         if (chipselect && !write_n && ch == c) begin
            case (rg)
               0: out_m[c]  = wd;
               2: mask_m[c] = wd;
               3: clr       = wd;
               4: out_m[c]  = out_m[c] | wd;
               5: out_m[c]  = out_m[c] & ~wd;
               default: ;
            endcase
         end
         edge_m[c] = (edge_m[c] & ~clr) | rise;
         smp3[c] = smp2[c];
         smp2[c] = smp1[c];
         smp1[c] = in_port[c*DW +: DW];
      end
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_port", 128'(out_port), 128'(model_out()));
         chk("irq", 128'(irq), 128'(exp_irq));
         chk("readdatavalid", 128'(readdatavalid), 128'(exp_rdv));
         chk("readdata", 128'(readdata), 128'(exp_rd));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      chipselect = 1'b0; read = 1'b0; write_n = 1'b1;
   endtask

   task automatic wr(int ch, int rg, logic [31:0] d);
      address = AW'(ch * 8 + rg); writedata = d;
      chipselect = 1'b1; write_n = 1'b0; read = 1'b0;
      tick();
      idle();
   endtask

   task automatic rd(int ch, int rg, output logic [31:0] v);
      address = AW'(ch * 8 + rg);
      chipselect = 1'b1; read = 1'b1; write_n = 1'b1;
      tick();
      idle();
      chk("rd_valid_pulse", 128'(readdatavalid), 128'(1'b1));
      v = readdata;
   endtask

   logic [31:0] v;

   initial begin
      reset_n = 1'b0; idle(); address = '0; writedata = 32'h0; in_port = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      chk("reset_out_port", 128'(out_port), 128'h0);
      chk("reset_irq", 128'(irq), 128'h0);
      chk("reset_rdv", 128'(readdatavalid), 128'h0);
      chk_en = 1'b1;
      rd(0, 0, v);  chk("reset_data_ch0", 128'(v), 128'h0);

      // Set/clear aliases on channel 1.
      wr(1, 0, 32'h0000_00F0);
      wr(1, 4, 32'h0000_0003);
      wr(1, 5, 32'h0000_0010);
      chk("setclr_out_ch1", 128'(out_port[31:16]), 128'h00E3);
      rd(1, 0, v);  chk("setclr_read_ch1", 128'(v), 128'h0000_00E3);

      // Unmasked edge and irq on channel 2 bit 2.
      wr(2, 2, 32'h0000_0004);
      in_port[2*DW + 2] = 1'b1;
      tick(); tick();
      chk("edge_irq_early", 128'(irq), 128'h0);
      tick();
      chk("edge_irq_cycle3", 128'(irq), 128'h0);
      rd(2, 3, v);  chk("edge_ch2_set", 128'(v), 128'h0004);
      chk("edge_irq_rise", 128'(irq), 128'h1);
      wr(2, 3, 32'h0000_0004);
      tick();
      chk("edge_irq_cleared", 128'(irq), 128'h0);

      // Masked edge on channel 2 bit 3.
      in_port[2*DW + 3] = 1'b1;
      repeat (4) tick();
      chk("masked_irq_low", 128'(irq), 128'h0);
      rd(2, 3, v);  chk("masked_edge_ch2", 128'(v), 128'h0008);

      // W1C on ch0 bit0 at the same edge a new rise is detected.
      in_port[0] = 1'b1;
      tick(); tick();
      wr(0, 3, 32'h0000_0001);
      rd(0, 3, v);  chk("collision_edge_ch0", 128'(v), 128'h0001);

      // Width truncation and unpopulated channels.
      wr(0, 0, 32'hFFFF_FFFF);
      rd(0, 0, v);  chk("width_read_ch0", 128'(v), 128'h0000_FFFF);
      wr(5, 0, 32'h0000_1234);
      wr(7, 4, 32'h0000_FFFF);
      chk("oor_out_port", 128'(out_port), 128'h0000_0000_0000_00E3_FFFF);
      rd(5, 0, v);  chk("oor_read_zero", 128'(v), 128'h0);

      // Random bus and input traffic.
      for (int i = 0; i < 3000; i++) begin
         chipselect = ($urandom_range(0, 3) != 0);
         read       = 1'($urandom_range(0, 1));
         write_n    = 1'($urandom_range(0, 1));
         address    = AW'($urandom);
         writedata  = $urandom;
         if ($urandom_range(0, 2) == 0) in_port[$urandom_range(0, NB-1)] ^= 1'b1;
         tick();
      end
      idle();
      tick();

      // Reset asserted with a read response outstanding.
      address = AW'(1 * 8 + 0); chipselect = 1'b1; read = 1'b1; write_n = 1'b1;
      tick();
      idle();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_out_port", 128'(out_port), 128'h0);
      chk("midrst_irq", 128'(irq), 128'h0);
      chk("midrst_rdv", 128'(readdatavalid), 128'h0);
      chk("midrst_readdata", 128'(readdata), 128'h0);
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      rd(0, 0, v);  chk("midrst_data_ch0", 128'(v), 128'h0);
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
